// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet parser.
// State and error-code encodings are common to the parser and any consumer of err_code.
package uart_pkg;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CSUM    = 3'd3,
      ST_DRAIN   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      ERR_BAD_LEN = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_OVERRUN = 2'd3
   } err_code_e;

   // Address width for a register array, never below one bit.
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x 8 register array, one synchronous write port and
// one combinational read port.
module uart_pkt_buf #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [7:0]    i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [7:0]    o_rd_data
);

   logic [7:0] r_mem [DEPTH];

   // NOTE: storage arrays get no reset; every entry is written before it is read.
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_pkt_parser.sv
// Frame parser behind a UART receiver: SYNC, LEN, payload, checksum, then replay.
// Optional inter-byte timeout is built only when UART_PKT_TIMEOUT_EN is defined.
module uart_pkt_parser
   import uart_pkg::*;
#(
   parameter int unsigned MAX_LEN     = 16,
   parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam int unsigned IDX_W = $clog2(MAX_LEN + 1);
   localparam int unsigned AW    = addr_width(MAX_LEN);

   localparam logic [7:0]       LEN_MAX = 8'(MAX_LEN);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   localparam logic [2:0] S_HUNT    = ST_HUNT;
   localparam logic [2:0] S_LEN     = ST_LEN;
   localparam logic [2:0] S_PAYLOAD = ST_PAYLOAD;
   localparam logic [2:0] S_CSUM    = ST_CSUM;
   localparam logic [2:0] S_DRAIN   = ST_DRAIN;

   logic [2:0]       r_state;
   logic [IDX_W-1:0] r_len;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_rd_idx;
   logic [7:0]       r_csum;
   logic             r_m_valid;
   logic             r_frame_ok;
   logic             r_frame_err;
   logic [1:0]       r_err_code;

   logic [7:0]       w_csum_sum;
   logic             w_len_bad;
   logic             w_wr_en;
   logic [IDX_W-1:0] w_last_idx;
   logic [7:0]       w_rd_data;
   logic             w_handshake;
   logic             w_tmo_expire;

   assign w_csum_sum  = r_csum + rx_byte;
   assign w_len_bad   = (rx_byte == 8'd0) || (rx_byte > LEN_MAX);
   assign w_wr_en     = (r_state == S_PAYLOAD) && rx_valid;
   assign w_last_idx  = r_len - IDX_ONE;
   assign w_handshake = r_m_valid && m_ready;

   uart_pkt_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_idx[AW-1:0]),
      .i_wr_data (rx_byte),
      .i_rd_addr (r_rd_idx[AW-1:0]),
      .o_rd_data (w_rd_data)
   );

`ifdef UART_PKT_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             w_tmo_armed;

   assign w_tmo_armed  = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);
   // A byte landing on the expiry cycle masks the timeout and is parsed normally.
   assign w_tmo_expire = w_tmo_armed && !rx_valid && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tmo_cnt <= '0;
      end else if (rx_valid || !w_tmo_armed || w_tmo_expire) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end
`else
   logic [31:0] w_unused_timeout_cyc;

   assign w_unused_timeout_cyc = TIMEOUT_CYC;
   assign w_tmo_expire         = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_HUNT;
         r_len       <= '0;
         r_idx       <= '0;
         r_rd_idx    <= '0;
         r_csum      <= '0;
         r_m_valid   <= 1'b0;
         r_frame_ok  <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_code  <= '0;
      end else begin
         // NOTE: pulse outputs default low every cycle; the cases below raise them for one cycle.
         r_frame_ok  <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_code  <= '0;

         case (r_state)
            S_HUNT: begin
               if (rx_valid && (rx_byte == SYNC_BYTE)) r_state <= S_LEN;
            end

            S_LEN: begin
               if (rx_valid) begin
                  if (w_len_bad) begin
                     r_frame_err <= 1'b1;
                     r_err_code  <= ERR_BAD_LEN;
                     r_state     <= S_HUNT;
                  end else begin
                     r_len   <= rx_byte[IDX_W-1:0];
                     r_csum  <= rx_byte;
                     r_idx   <= '0;
                     r_state <= S_PAYLOAD;
                  end
               end
            end

            S_PAYLOAD: begin
               if (rx_valid) begin
                  r_csum <= w_csum_sum;
                  r_idx  <= r_idx + IDX_ONE;
                  if (r_idx == w_last_idx) r_state <= S_CSUM;
               end
            end

            S_CSUM: begin
               if (rx_valid) begin
                  if (w_csum_sum == 8'd0) begin
                     r_frame_ok <= 1'b1;
                     r_m_valid  <= 1'b1;
                     r_rd_idx   <= '0;
                     r_state    <= S_DRAIN;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_err_code  <= ERR_CSUM;
                     r_state     <= S_HUNT;
                  end
               end
            end

            S_DRAIN: begin
               // Bytes arriving while replaying are lost; the replay itself is untouched.
               if (rx_valid) begin
                  r_frame_err <= 1'b1;
                  r_err_code  <= ERR_OVERRUN;
               end
               if (w_handshake) begin
                  if (r_rd_idx == w_last_idx) begin
                     r_m_valid <= 1'b0;
                     r_state   <= S_HUNT;
                  end else begin
                     r_rd_idx <= r_rd_idx + IDX_ONE;
                  end
               end
            end

            default: r_state <= S_HUNT;
         endcase

         if (w_tmo_expire) begin
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
            r_state     <= S_HUNT;
         end
      end
   end

   assign m_valid   = r_m_valid;
   assign m_data    = r_m_valid ? w_rd_data : 8'd0;
   assign m_last    = r_m_valid && (r_rd_idx == w_last_idx);
   assign frame_ok  = r_frame_ok;
   assign frame_err = r_frame_err;
   assign err_code  = r_err_code;
   assign busy      = (r_state != S_HUNT);

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Scoreboard bench for uart_pkt_parser: stimulus pushes expected bytes/events,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_uart_pkt_parser;

   localparam int EV_OK = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_byte = 8'd0;
   logic       rx_valid = 1'b0;
   logic       m_ready = 1'b1;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [8:0] byte_q [$];
   int         ev_q   [$];

   logic       prev_stall = 1'b0;
   logic [9:0] prev_out   = '0;

   uart_pkt_parser #(
      .MAX_LEN     (16),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (50)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, what);
   endtask

   // Monitor: outputs change only at posedge, inputs at posedge+2, so negedge is quiet.
   always @(negedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (frame_ok && frame_err) fail_now("ok_err_exclusive", "frame_ok and frame_err both high");
         if (frame_ok) begin
            if (ev_q.size() == 0) fail_now("frame_ok", "unexpected frame_ok pulse");
            else check("frame_ok", EV_OK, ev_q.pop_front());
         end
         if (frame_err) begin
            if (ev_q.size() == 0) fail_now("frame_err", $sformatf("unexpected error code %0d", err_code));
            else check("frame_err_code", {30'd0, err_code}, ev_q.pop_front());
         end
         if (prev_stall) check("stall_hold", {m_valid, m_last, m_data}, prev_out);
         if (m_valid && m_ready) begin
            if (byte_q.size() == 0) fail_now("m_data", $sformatf("unexpected byte %0h", m_data));
            else check("m_data_last", {m_last, m_data}, byte_q.pop_front());
         end
         prev_stall = m_valid && !m_ready;
         prev_out   = {m_valid, m_last, m_data};
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #2;
      rx_byte  = b;
      rx_valid = 1'b1;
      @(posedge clk); #2;
      rx_valid = 1'b0;
      rx_byte  = 8'd0;
   endtask

   // Payload byte 0 sits in bits [7:0].
   task automatic send_frame(input logic [7:0] len_b, input logic [127:0] pl, input int n,
                             input logic [7:0] csum_b);
      send_byte(8'hA5);
      send_byte(len_b);
      for (int i = 0; i < n; i++) send_byte(pl[i*8 +: 8]);
      send_byte(csum_b);
   endtask

   task automatic expect_payload(input logic [127:0] pl, input int n);
      for (int i = 0; i < n; i++) byte_q.push_back({(i == n - 1), pl[i*8 +: 8]});
   endtask

   task automatic drain(input string name, input logic [3:0] pat);
      int c;
      c = 0;
      while (byte_q.size() != 0 && c < 200) begin
         @(posedge clk); #2;
         m_ready = pat[c % 4];
         c++;
      end
      if (byte_q.size() != 0) begin
         fail_now(name, "drain did not complete within 200 cycles");
         byte_q.delete();
      end
      @(posedge clk); #2;
      m_ready = 1'b1;
      check({name, "_idle"}, {30'd0, m_valid, busy}, 32'd0);
   endtask

   initial begin
      // Reset state
      #3;
      check("reset_outputs", {m_data, m_valid, m_last, frame_ok, frame_err, err_code, busy}, 32'd0);
      #20 rst = 1'b1;
      @(posedge clk); #2;
      check("post_reset_outputs", {m_data, m_valid, m_last, frame_ok, frame_err, err_code, busy}, 32'd0);

      // 1 Good frame: 03+11+22+33+97 = 0x100
      ev_q.push_back(EV_OK);
      expect_payload(128'h332211, 3);
      send_frame(8'h03, 128'h332211, 3, 8'h97);
      drain("good_frame", 4'b1111);

      // 2 Backpressure with ready pattern 1,0,0,1
      m_ready = 1'b0;
      ev_q.push_back(EV_OK);
      expect_payload(128'h332211, 3);
      send_frame(8'h03, 128'h332211, 3, 8'h97);
      drain("backpressure", 4'b1001);

      // 3 Bad checksums: 02+01+02+00 = 05; 03+11+22+33+89 = 0xF2
      ev_q.push_back(1);
      send_frame(8'h02, 128'h0201, 2, 8'h00);
      check("bad_csum_busy", {31'd0, busy}, 32'd0);
      ev_q.push_back(1);
      send_frame(8'h03, 128'h332211, 3, 8'h89);
      check("bad_csum2_busy", {31'd0, busy}, 32'd0);

      // 4 Bad lengths: 0, 17, 255
      ev_q.push_back(0);
      send_byte(8'hA5);
      check("after_sync_busy", {31'd0, busy}, 32'd1);
      send_byte(8'h00);
      check("len0_busy", {31'd0, busy}, 32'd0);
      ev_q.push_back(0);
      send_byte(8'hA5);
      send_byte(8'h11);
      check("len17_busy", {31'd0, busy}, 32'd0);
      ev_q.push_back(0);
      send_byte(8'hA5);
      send_byte(8'hFF);
      check("len255_busy", {31'd0, busy}, 32'd0);

      // Max length frame: 10 + sum(1..16)=0x98, csum 0x68
      ev_q.push_back(EV_OK);
      expect_payload(128'h100F0E0D0C0B0A090807060504030201, 16);
      send_frame(8'h10, 128'h100F0E0D0C0B0A090807060504030201, 16, 8'h68);
      drain("max_len", 4'b1111);

      // 5 Noise then sync: 01+7E+81 = 0x100
      send_byte(8'h00);
      send_byte(8'hFF);
      check("noise_busy", {31'd0, busy}, 32'd0);
      ev_q.push_back(EV_OK);
      expect_payload(128'h7E, 1);
      send_frame(8'h01, 128'h7E, 1, 8'h81);
      drain("noise_sync", 4'b1111);

      // 6 Overrun during drain
      m_ready = 1'b0;
      ev_q.push_back(EV_OK);
      expect_payload(128'h332211, 3);
      send_frame(8'h03, 128'h332211, 3, 8'h97);
      ev_q.push_back(3);
      send_byte(8'h55);
      check("overrun_still_draining", {30'd0, m_valid, busy}, 32'd3);
      drain("overrun", 4'b1111);

      // 7/8 Stall after one payload byte of a 4-byte frame
`ifdef UART_PKT_TIMEOUT_EN
      ev_q.push_back(2);
`endif
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h11);
      repeat (60) @(posedge clk);
      #2;
`ifdef UART_PKT_TIMEOUT_EN
      check("timeout_busy", {31'd0, busy}, 32'd0);
`else
      check("no_timeout_busy", {31'd0, busy}, 32'd1);
      // 04+11+22+33+44 = 0xAE, csum 0x52
      ev_q.push_back(EV_OK);
      expect_payload(128'h44332211, 4);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h52);
      drain("resume_after_stall", 4'b1111);
`endif

      // 9 Reset mid-drain
      m_ready = 1'b0;
      ev_q.push_back(EV_OK);
      expect_payload(128'h332211, 3);
      send_frame(8'h03, 128'h332211, 3, 8'h97);
      begin
         int c;
         c = 0;
         while (!m_valid && c < 50) begin
            @(posedge clk); #2;
            c++;
         end
         if (!m_valid) fail_now("reset_drain_start", "m_valid never rose");
      end
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("async_reset_outputs", {m_data, m_valid, m_last, frame_ok, frame_err, busy}, 32'd0);
      byte_q.delete();
      #5 rst = 1'b1;
      m_ready = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      check("after_reset_idle", {30'd0, m_valid, busy}, 32'd0);

      repeat (3) @(posedge clk);
      check("events_left", ev_q.size(), 32'd0);
      check("bytes_left", byte_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
